// File: rtl/iir_pkg.sv
// Shared widths, FSM encoding and default coefficients for the Direct Form I biquad.
// Default coefficients: 2nd-order Butterworth highpass, fc = 150 Hz at fs = 1 kHz.
package iir_pkg;

  localparam int unsigned SampleW  = 16;
  localparam int unsigned CoefW    = 16;
  localparam int unsigned FracBits = 14;
  localparam int unsigned AccW     = 36;
  localparam int unsigned ProdW    = SampleW + CoefW;
  localparam int unsigned RndW     = AccW - FracBits;
  localparam int unsigned TapW     = 3;

  localparam logic [TapW-1:0] LastTap = 3'd4;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StOut
  } state_e;

  localparam logic signed [CoefW-1:0] DefB0 = 16'sd8274;
  localparam logic signed [CoefW-1:0] DefB1 = -16'sd16548;
  localparam logic signed [CoefW-1:0] DefB2 = 16'sd8274;
  localparam logic signed [CoefW-1:0] DefA1 = -16'sd12252;
  localparam logic signed [CoefW-1:0] DefA2 = 16'sd4460;

  localparam logic signed [SampleW-1:0] SampleMax = 16'sh7FFF;
  localparam logic signed [SampleW-1:0] SampleMin = 16'sh8000;

  // Half an LSB of the Q2.14 result, expressed in accumulator (Q8.28) units.
  localparam logic signed [AccW-1:0] RoundHalf = AccW'(1) << (FracBits - 1);

endpackage

// File: rtl/iir_mac.sv
// Shared signed 16x16 multiplier feeding a 36-bit add/subtract accumulator.
// The product is not registered; product plus accumulator settle in one cycle.
module iir_mac
  import iir_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     sub,
  input  logic signed [CoefW-1:0]  coef,
  input  logic signed [SampleW-1:0] data,
  output logic signed [AccW-1:0]   acc
);

  logic signed [ProdW-1:0] coef_ext;
  logic signed [ProdW-1:0] data_ext;
  logic signed [ProdW-1:0] prod;
  logic signed [AccW-1:0]  prod_ext;
  logic signed [AccW-1:0]  acc_d;
  logic signed [AccW-1:0]  acc_q;

  assign coef_ext = ProdW'(coef);
  assign data_ext = ProdW'(data);
  assign prod     = coef_ext * data_ext;
  assign prod_ext = {{(AccW - ProdW){prod[ProdW-1]}}, prod};

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = sub ? (acc_q - prod_ext) : (acc_q + prod_ext);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/iir_biquad_df1.sv
// Direct Form I biquad, one sample per 7 clocks through a shared MAC (5 taps).
// Define BIQUAD_SAT_EN to clamp the output instead of two's-complement wrapping.
module iir_biquad_df1
  import iir_pkg::*;
#(
  parameter logic signed [CoefW-1:0] B0 = DefB0,
  parameter logic signed [CoefW-1:0] B1 = DefB1,
  parameter logic signed [CoefW-1:0] B2 = DefB2,
  parameter logic signed [CoefW-1:0] A1 = DefA1,
  parameter logic signed [CoefW-1:0] A2 = DefA2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [SampleW-1:0] in_data,
  output logic                      out_valid,
  output logic signed [SampleW-1:0] out_data
);

  state_e state_q, state_d;
  logic [TapW-1:0] k_q, k_d;

  logic signed [SampleW-1:0] x0_q, x1_q, x2_q, y1_q, y2_q;
  logic signed [SampleW-1:0] out_data_q;
  logic                      out_valid_q;

  logic                      accept;
  logic                      mac_en;
  logic                      mac_clr;
  logic                      mac_sub;
  logic signed [CoefW-1:0]   mac_coef;
  logic signed [SampleW-1:0] mac_data;
  logic signed [AccW-1:0]    acc;
  logic signed [AccW-1:0]    acc_rnd;
  logic signed [RndW-1:0]    rnd;
  logic signed [SampleW-1:0] y_new;

  assign in_ready = (state_q == StIdle);
  assign accept   = in_ready & in_valid & ~clr;

  // Control: clr overrides everything, including a sample offered in IDLE.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    if (clr) begin
      state_d = StIdle;
      k_d     = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            state_d = StMac;
            k_d     = '0;
          end
        end
        StMac: begin
          if (k_q == LastTap) begin
            state_d = StOut;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
        StOut:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Tap k selects one coefficient/sample pair; feedback terms are subtracted.
  always_comb begin
    mac_coef = B0;
    mac_data = x0_q;
    mac_sub  = 1'b0;
    case (k_q)
      3'd1: begin
        mac_coef = B1;
        mac_data = x1_q;
      end
      3'd2: begin
        mac_coef = B2;
        mac_data = x2_q;
      end
      3'd3: begin
        mac_coef = A1;
        mac_data = y1_q;
        mac_sub  = 1'b1;
      end
      3'd4: begin
        mac_coef = A2;
        mac_data = y2_q;
        mac_sub  = 1'b1;
      end
      default: ;
    endcase
  end

  assign mac_en  = (state_q == StMac) & ~clr;
  assign mac_clr = clr | accept;

  iir_mac u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mac_clr),
    .en    (mac_en),
    .sub   (mac_sub),
    .coef  (mac_coef),
    .data  (mac_data),
    .acc   (acc)
  );

  // Round half up, then drop the 14 fraction bits (arithmetic shift).
  assign acc_rnd = acc + RoundHalf;
  assign rnd     = acc_rnd[AccW-1:FracBits];

`ifdef BIQUAD_SAT_EN
  logic [RndW-SampleW:0] rnd_hi;
  logic                  rnd_ovf;
  logic                  unused_rnd;

  assign rnd_hi     = rnd[RndW-1:SampleW-1];
  assign rnd_ovf    = ~((&rnd_hi) | ~(|rnd_hi));
  assign y_new      = rnd_ovf ? (rnd[RndW-1] ? SampleMin : SampleMax) : rnd[SampleW-1:0];
  assign unused_rnd = ^acc_rnd[FracBits-1:0];
`else
  logic unused_rnd;

  assign y_new      = rnd[SampleW-1:0];
  assign unused_rnd = ^{acc_rnd[FracBits-1:0], rnd[RndW-1:SampleW]};
`endif

  // Delay line and output register; y1 takes the narrowed value so feedback matches out_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0_q        <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      y1_q        <= '0;
      y2_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (clr) begin
      x0_q        <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      y1_q        <= '0;
      y2_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= (state_q == StOut);
      if (accept) begin
        x0_q <= in_data;
      end
      if (state_q == StOut) begin
        x2_q       <= x1_q;
        x1_q       <= x0_q;
        y2_q       <= y1_q;
        y1_q       <= y_new;
        out_data_q <= y_new;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_iir_biquad_df1.sv
// Bench for iir_biquad_df1: difference-equation model plus directed impulse/step/clr/reset cases.
module tb_iir_biquad_df1;

  localparam int CB0 = 8274;
  localparam int CB1 = -16548;
  localparam int CB2 = 8274;
  localparam int CA1 = -12252;
  localparam int CA2 = 4460;

`ifdef BIQUAD_SAT_EN
  localparam int SatExp = 32767;
`else
  localparam int SatExp = -4;
`endif

  logic               clk;
  logic               rst_n;
  logic               clr;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic               out_valid;
  logic signed [15:0] out_data;

  logic               s_in_valid;
  logic               s_in_ready;
  logic signed [15:0] s_in_data;
  logic               s_out_valid;
  logic signed [15:0] s_out_data;

  iir_biquad_df1 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  iir_biquad_df1 #(
    .B0 (16'sd32767),
    .B1 (16'sd0),
    .B2 (16'sd0),
    .A1 (16'sd0),
    .A2 (16'sd0)
  ) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (1'b0),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_data   (s_in_data),
    .out_valid (s_out_valid),
    .out_data  (s_out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int y;
    int e;
  } exp_t;

  int   xh[$];
  int   yh[$];
  exp_t expq[$];
  int   got[$];
  int   acc_edges[$];
  int   edge_cnt = 0;
  int   busy_until = 0;
  int   held_y = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_le(input string name, input int act, input int lim);
    checks++;
    if (act > lim) begin
      errors++;
      $display("FAIL %s: got %0d expected <= %0d", name, act, lim);
    end
  endtask

  // y[n] = b0 x[n] + b1 x[n-1] + b2 x[n-2] - a1 y[n-1] - a2 y[n-2], Q2.14 in and out.
  function automatic int model_step(input int x);
    longint acc;
    longint r;
    int x1, x2, y1, y2;
    x1 = (xh.size() > 0) ? xh[0] : 0;
    x2 = (xh.size() > 1) ? xh[1] : 0;
    y1 = (yh.size() > 0) ? yh[0] : 0;
    y2 = (yh.size() > 1) ? yh[1] : 0;
    acc = longint'(CB0) * x + longint'(CB1) * x1 + longint'(CB2) * x2
        - longint'(CA1) * y1 - longint'(CA2) * y2;
    r = (acc + 8192) >>> 14;
`ifdef BIQUAD_SAT_EN
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`else
    r = r & 64'hFFFF;
    if (r >= 32768) r = r - 65536;
`endif
    xh.push_front(x);
    yh.push_front(int'(r));
    if (xh.size() > 2) void'(xh.pop_back());
    if (yh.size() > 2) void'(yh.pop_back());
    return int'(r);
  endfunction

  // Acceptance tracker: decides readiness from its own timing model, never from in_ready.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xh.delete();
      yh.delete();
      expq.delete();
      busy_until = 0;
      held_y = 0;
    end else begin
      if (clr) begin
        edge_cnt++;
        xh.delete();
        yh.delete();
        expq.delete();
        busy_until = edge_cnt;
        held_y = 0;
      end else if (in_valid && edge_cnt >= busy_until) begin
        exp_t e;
        edge_cnt++;
        e.y = model_step(int'(in_data));
        e.e = edge_cnt + 6;
        expq.push_back(e);
        acc_edges.push_back(edge_cnt);
        busy_until = edge_cnt + 6;
      end else begin
        edge_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", int'(in_ready), int'(edge_cnt >= busy_until));
      while (expq.size() > 0 && expq[0].e < edge_cnt) begin
        chk("out_valid_missing", 0, 1);
        void'(expq.pop_front());
      end
      if (out_valid) begin
        if (expq.size() == 0) begin
          chk("out_valid_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("out_latency_edge", edge_cnt, e.e);
          chk("out_data", int'(out_data), e.y);
          held_y = e.y;
        end
        got.push_back(int'(out_data));
      end else begin
        chk("out_data_hold", int'(out_data), held_y);
      end
    end
  end

  task automatic drive_one(input int x);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_data  = 16'(x);
    @(negedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_got(input int target);
    int n;
    n = 0;
    while (got.size() < target && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (got.size() < target) chk("output_timeout", got.size(), target);
  endtask

  task automatic run_impulse(input string tag);
    int base;
    base = got.size();
    drive_one(16384);
    drive_one(0);
    drive_one(0);
    drive_one(0);
    wait_got(base + 4);
    if (got.size() >= base + 3) begin
      chk({tag, "_y0"}, got[base], 8274);
      chk({tag, "_y1"}, got[base + 1], -10361);
      chk({tag, "_y2"}, got[base + 2], -1726);
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    int base;
    int a0;
    int n;
    int b2b_tab[8];
    b2b_tab = '{12000, -12000, 32767, -32768, 0, 4096, -1, 20000};

    rst_n      = 1'b0;
    clr        = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    s_in_valid = 1'b0;
    s_in_data  = '0;
    #12;
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_data", int'(out_data), 0);

    run_impulse("impulse");

    // clr during tap k=2 with in_valid held: the sample is dropped and history zeroed.
    in_valid = 1'b1;
    in_data  = 16'sd16384;
    @(negedge clk);
    #1;
    @(negedge clk);
    #1;
    @(negedge clk);
    #1;
    clr = 1'b1;
    @(negedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    base = got.size();
    repeat (10) begin
      @(negedge clk);
      #1;
    end
    chk("clr_no_output", got.size(), base);
    chk("clr_out_data", int'(out_data), 0);
    run_impulse("post_clr");

    // DC step: highpass must settle near zero.
    pulse_clr();
    base = got.size();
    for (int i = 0; i < 64; i++) drive_one(8192);
    wait_got(base + 64);
    if (got.size() >= base + 64) begin
      chk("dc_first", got[base], 4137);
      chk_le("dc_reject", (got[base + 63] < 0) ? -got[base + 63] : got[base + 63], 2);
    end

    // Back-to-back: in_valid held high, data changing every cycle.
    pulse_clr();
    a0 = acc_edges.size();
    base = got.size();
    in_valid = 1'b1;
    for (int i = 0; i < 56; i++) begin
      in_data = 16'(b2b_tab[i % 8]);
      @(negedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_got(base + 8);
    chk("b2b_accept_count", acc_edges.size() - a0, 8);
    for (int i = a0 + 1; i < acc_edges.size(); i++) begin
      chk("b2b_accept_spacing", acc_edges[i] - acc_edges[i - 1], 7);
    end

    // Async reset between edges in the middle of the MAC phase.
    in_valid = 1'b1;
    in_data  = 16'sd16384;
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_data", int'(out_data), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    run_impulse("post_reset");

    // Overflowing product on the overridden-coefficient instance.
    s_in_valid = 1'b1;
    s_in_data  = 16'sd32767;
    @(negedge clk);
    #1;
    s_in_valid = 1'b0;
    n = 0;
    while (!s_out_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("sat_out_valid", int'(s_out_valid), 1);
    chk("sat_out_data", int'(s_out_data), SatExp);
    chk("sat_in_ready", int'(s_in_ready), 1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
